// File: rtl/clk_ratio_monitor_pkg.sv
// Shared types and constants for the generated-clock ratio monitor.
package clk_ratio_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    LOCKED  = 2'd3
  } mon_state_e;

  localparam int ERR_CNT_W = 8;

  // Error counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [ERR_CNT_W-1:0] sat_inc_err(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/edge_period_counter.sv
// Samples the monitored clock as data, detects its rising edge and counts
// the period and high time since the last rise (or timeout restart).
module edge_period_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             restart_i,
  input  logic             mon_clk_i,
  output logic             rise_o,
  output logic [CNT_W-1:0] period_cnt_o,
  output logic [CNT_W-1:0] high_cnt_o
);

  logic             mon_q;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;

  assign rise_o       = mon_clk_i & ~mon_q;
  assign period_cnt_o = period_cnt_q;
  assign high_cnt_o   = high_cnt_q;

  // Next counts: clear beats a rise, a rise beats a timeout restart.
  // A restart starts a fresh window from the current sample so that a stuck
  // clock keeps producing timeouts at a fixed interval.
  always_comb begin
    period_cnt_d = period_cnt_q;
    high_cnt_d   = high_cnt_q;
    if (clr_i) begin
      period_cnt_d = '0;
      high_cnt_d   = '0;
    end else if (rise_o) begin
      period_cnt_d = CNT_W'(1);
      high_cnt_d   = CNT_W'(1);
    end else if (restart_i) begin
      period_cnt_d = CNT_W'(1);
      high_cnt_d   = CNT_W'(mon_clk_i);
    end else begin
      if (~&period_cnt_q) period_cnt_d = period_cnt_q + CNT_W'(1);
      if (mon_clk_i && ~&high_cnt_q) high_cnt_d = high_cnt_q + CNT_W'(1);
    end
  end

  // Edge-detect history and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mon_q        <= 1'b0;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
    end else begin
      mon_q        <= mon_clk_i;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
    end
  end

endmodule

// File: rtl/clk_ratio_monitor.sv
// Checks a generated clock against its source clock: measures period and
// high time in source cycles, flags mismatches/timeouts, and reports lock
// after LOCK_COUNT consecutive good periods.
//
// state   | meaning
// IDLE    | disabled, counters and match run cleared
// ARM     | waiting for the first rise; that rise is not checked
// MEASURE | checking every period, match run below LOCK_COUNT
// LOCKED  | LOCK_COUNT consecutive good periods seen, still checking
module clk_ratio_monitor
  import clk_ratio_monitor_pkg::*;
#(
  parameter int DIV_RATIO   = 2,
  parameter int HIGH_CYCLES = DIV_RATIO / 2,
  parameter int LOCK_COUNT  = 4,
  parameter int CNT_W       = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 mon_clk,
  output logic                 valid,
  output logic [CNT_W-1:0]     period_out,
  output logic [CNT_W-1:0]     high_out,
  output logic                 err,
  output logic                 locked,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int MR_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] PERIOD_EXP = CNT_W'(DIV_RATIO);
  localparam logic [CNT_W-1:0] HIGH_EXP   = CNT_W'(HIGH_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT    = CNT_W'(2 * DIV_RATIO);
  localparam logic [MR_W-1:0]  LOCK_RUN   = MR_W'(LOCK_COUNT);

  logic [1:0]       rst_sync_q;
  logic             rst_sync_n;
  logic             rise;
  logic             timeout;
  logic             is_match;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] high_cnt;

  mon_state_e           state_q, state_d;
  logic [MR_W-1:0]      match_run_q, match_run_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic                 locked_q, locked_d;
  logic [CNT_W-1:0]     period_out_q, period_out_d;
  logic [CNT_W-1:0]     high_out_q, high_out_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  // Reset asserts immediately and releases two clk_in edges later.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_sync_n = rst_sync_q[1];

  edge_period_counter #(
    .CNT_W(CNT_W)
  ) u_edge_period_counter (
    .clk_i       (clk_in),
    .rst_ni      (rst_sync_n),
    .clr_i       (~enable),
    .restart_i   (timeout),
    .mon_clk_i   (mon_clk),
    .rise_o      (rise),
    .period_cnt_o(period_cnt),
    .high_cnt_o  (high_cnt)
  );

  assign is_match = (period_cnt == PERIOD_EXP) && (high_cnt == HIGH_EXP);
  // ARM also times out so a stuck clock keeps reporting while enabled.
  assign timeout  = enable && (state_q != IDLE) && !rise && (period_cnt >= TIMEOUT);

  // Next-state and output decode; a low enable overrides everything else.
  always_comb begin
    state_d      = state_q;
    match_run_d  = match_run_q;
    valid_d      = 1'b0;
    err_d        = 1'b0;
    period_out_d = period_out_q;
    high_out_d   = high_out_q;
    err_count_d  = err_count_q;
    if (!enable) begin
      state_d     = IDLE;
      match_run_d = '0;
    end else begin
      case (state_q)
        IDLE: state_d = ARM;
        ARM:  if (rise) state_d = MEASURE;
        MEASURE, LOCKED: begin
          if (rise) begin
            valid_d      = 1'b1;
            period_out_d = period_cnt;
            high_out_d   = high_cnt;
            if (is_match) begin
              if (match_run_q != LOCK_RUN) match_run_d = match_run_q + MR_W'(1);
              if (match_run_d == LOCK_RUN) state_d = LOCKED;
            end else begin
              err_d       = 1'b1;
              err_count_d = sat_inc_err(err_count_q);
              match_run_d = '0;
              state_d     = MEASURE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
      if (timeout) begin
        err_d        = 1'b1;
        err_count_d  = sat_inc_err(err_count_q);
        period_out_d = TIMEOUT;
        high_out_d   = high_cnt;
        match_run_d  = '0;
        state_d      = ARM;
      end
    end
    locked_d = (state_d == LOCKED);
  end

  // FSM state, match run and all registered outputs.
  always_ff @(posedge clk_in or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q      <= IDLE;
      match_run_q  <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      locked_q     <= 1'b0;
      period_out_q <= '0;
      high_out_q   <= '0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      match_run_q  <= match_run_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      locked_q     <= locked_d;
      period_out_q <= period_out_d;
      high_out_q   <= high_out_d;
      err_count_q  <= err_count_d;
    end
  end

  assign valid      = valid_q;
  assign err        = err_q;
  assign locked     = locked_q;
  assign period_out = period_out_q;
  assign high_out   = high_out_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// Bench for clk_ratio_monitor: a div-2 and a div-4 instance, a directed
// vector table, hand-written corner sequences and a randomized run, all
// checked against a cycle-count reference model.
module tb_clk_ratio_monitor;

  localparam int DIV_A  = 2;
  localparam int DIV_B  = 4;
  localparam int LOCK_N = 4;
  localparam int P_OFF = 0, P_ARMED = 1, P_CHECK = 2;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b1;
  logic en_a = 1'b0, mon_a = 1'b0, en_b = 1'b0, mon_b = 1'b0;
  logic valid_a, err_a, locked_a, valid_b, err_b, locked_b;
  logic [7:0] per_a, hi_a, ec_a, per_b, hi_b, ec_b;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  clk_ratio_monitor #(.DIV_RATIO(DIV_A), .LOCK_COUNT(LOCK_N), .CNT_W(8)) u_a (
    .clk_in(clk_in), .rst_n(rst_n), .enable(en_a), .mon_clk(mon_a),
    .valid(valid_a), .period_out(per_a), .high_out(hi_a),
    .err(err_a), .locked(locked_a), .err_count(ec_a));

  clk_ratio_monitor #(.DIV_RATIO(DIV_B), .LOCK_COUNT(LOCK_N), .CNT_W(8)) u_b (
    .clk_in(clk_in), .rst_n(rst_n), .enable(en_b), .mon_clk(mon_b),
    .valid(valid_b), .period_out(per_b), .high_out(hi_b),
    .err(err_b), .locked(locked_b), .err_count(ec_b));

  // Reference model: n/h are cycles and high samples since the window start.
  typedef struct {
    int phase; int run; int errs; bit prev;
    int n; int h; bit v; bit e; bit l; int p; int hi;
  } mdl_t;

  mdl_t ma, mb;

  function automatic void mdl_step(inout mdl_t m, input bit en, input bit mon,
                                   input int div, input int lock);
    bit rise;
    bit restart;
    rise    = mon && !m.prev;
    restart = 1'b0;
    m.prev  = mon;
    m.v = 1'b0;
    m.e = 1'b0;
    if (!en) begin
      m.phase = P_OFF; m.run = 0; m.l = 1'b0; m.n = 0; m.h = 0;
      return;
    end
    if (m.phase == P_OFF) begin
      m.phase = P_ARMED;
    end else if (rise) begin
      if (m.phase == P_ARMED) m.phase = P_CHECK;
      else begin
        m.v = 1'b1; m.p = m.n; m.hi = m.h;
        if (m.n == div && m.h == div / 2) m.run = (m.run < lock) ? m.run + 1 : lock;
        else begin
          m.e = 1'b1; m.run = 0;
          if (m.errs < 255) m.errs++;
        end
      end
    end else if (m.n >= 2 * div) begin
      m.e = 1'b1;
      if (m.errs < 255) m.errs++;
      m.p = 2 * div; m.hi = m.h; m.run = 0; m.phase = P_ARMED; restart = 1'b1;
    end
    m.l = (m.phase == P_CHECK) && (m.run == lock);
    if (rise || restart) begin
      m.n = 1; m.h = int'(mon);
    end else begin
      m.n = (m.n < 255) ? m.n + 1 : 255;
      if (mon && m.h < 255) m.h++;
    end
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic cmp_dut(input string nm, input mdl_t m, input logic v, input logic e,
                         input logic l, input logic [7:0] p, input logic [7:0] hi,
                         input logic [7:0] ec);
    checks++;
    if (v !== m.v || e !== m.e || l !== m.l || p !== 8'(m.p) || hi !== 8'(m.hi) ||
        ec !== 8'(m.errs)) begin
      errors++;
      $display("FAIL %s t=%0t valid/err/locked/period/high/err_count got %b/%b/%b/%0d/%0d/%0d want %b/%b/%b/%0d/%0d/%0d",
               nm, $time, v, e, l, p, hi, ec, m.v, m.e, m.l, m.p, m.hi, m.errs);
    end
  endtask

  task automatic cycle();
    @(posedge clk_in);
    #1;
    mdl_step(ma, en_a, mon_a, DIV_A, LOCK_N);
    mdl_step(mb, en_b, mon_b, DIV_B, LOCK_N);
    cmp_dut("model_a", ma, valid_a, err_a, locked_a, per_a, hi_a, ec_a);
    cmp_dut("model_b", mb, valid_b, err_b, locked_b, per_b, hi_b, ec_b);
  endtask

  task automatic do_reset();
    en_a = 1'b0; mon_a = 1'b0; en_b = 1'b0; mon_b = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk_in);
    #1;
    ma = '{default: 0};
    mb = '{default: 0};
  endtask

  typedef struct { bit en; bit mon; bit v; bit e; bit l; int p; int hi; int ec; } vec_t;
  vec_t tbl [29];

  int pa, ha, ra, posa, pb, hb, rb, posb;

  task automatic new_seg(input int div, output int p, output int h, output int r);
    int sel;
    sel = $urandom_range(0, 7);
    p = div;
    h = div / 2;
    if (sel == 4) h = 0;
    else if (sel == 5) h = p;
    else if (sel >= 6) begin
      p = $urandom_range(1, 2 * div + 3);
      h = $urandom_range(1, p);
    end
    r = $urandom_range(5, 40);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // div-2 lock, stall timeouts, then re-lock (en, mon, valid, err, locked, period, high, err_count)
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{1, 1, 1, 0, 0, 2, 1, 0};
    tbl[4]  = '{1, 0, 0, 0, 0, 2, 1, 0};
    tbl[5]  = '{1, 1, 1, 0, 0, 2, 1, 0};
    tbl[6]  = '{1, 0, 0, 0, 0, 2, 1, 0};
    tbl[7]  = '{1, 1, 1, 0, 0, 2, 1, 0};
    tbl[8]  = '{1, 0, 0, 0, 0, 2, 1, 0};
    tbl[9]  = '{1, 1, 1, 0, 1, 2, 1, 0};
    tbl[10] = '{1, 0, 0, 0, 1, 2, 1, 0};
    tbl[11] = '{1, 1, 1, 0, 1, 2, 1, 0};
    tbl[12] = '{1, 0, 0, 0, 1, 2, 1, 0};
    tbl[13] = '{1, 0, 0, 0, 1, 2, 1, 0};
    tbl[14] = '{1, 0, 0, 0, 1, 2, 1, 0};
    tbl[15] = '{1, 0, 0, 1, 0, 4, 1, 1};
    tbl[16] = '{1, 0, 0, 0, 0, 4, 1, 1};
    tbl[17] = '{1, 0, 0, 0, 0, 4, 1, 1};
    tbl[18] = '{1, 0, 0, 0, 0, 4, 1, 1};
    tbl[19] = '{1, 0, 0, 1, 0, 4, 0, 2};
    tbl[20] = '{1, 1, 0, 0, 0, 4, 0, 2};
    tbl[21] = '{1, 0, 0, 0, 0, 4, 0, 2};
    tbl[22] = '{1, 1, 1, 0, 0, 2, 1, 2};
    tbl[23] = '{1, 0, 0, 0, 0, 2, 1, 2};
    tbl[24] = '{1, 1, 1, 0, 0, 2, 1, 2};
    tbl[25] = '{1, 0, 0, 0, 0, 2, 1, 2};
    tbl[26] = '{1, 1, 1, 0, 0, 2, 1, 2};
    tbl[27] = '{1, 0, 0, 0, 0, 2, 1, 2};
    tbl[28] = '{1, 1, 1, 0, 1, 2, 1, 2};

    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_outputs_a", int'({valid_a, err_a, locked_a, per_a, hi_a, ec_a}), 0);
    chk("reset_outputs_b", int'({valid_b, err_b, locked_b, per_b, hi_b, ec_b}), 0);
    do_reset();

    for (int i = 0; i < 29; i++) begin
      en_a  = tbl[i].en;
      mon_a = tbl[i].mon;
      cycle();
      checks++;
      if (valid_a !== tbl[i].v || err_a !== tbl[i].e || locked_a !== tbl[i].l ||
          per_a !== 8'(tbl[i].p) || hi_a !== 8'(tbl[i].hi) || ec_a !== 8'(tbl[i].ec)) begin
        errors++;
        $display("FAIL table_a[%0d] got v%b e%b l%b p%0d h%0d c%0d want v%b e%b l%b p%0d h%0d c%0d",
                 i, valid_a, err_a, locked_a, per_a, hi_a, ec_a, tbl[i].v, tbl[i].e,
                 tbl[i].l, tbl[i].p, tbl[i].hi, tbl[i].ec);
      end
    end

    // Reset while locked clears outputs without waiting for a clock edge.
    chk("locked_before_reset", int'(locked_a), 1);
    rst_n = 1'b0;
    #1;
    chk("midlock_reset_a", int'({valid_a, err_a, locked_a, per_a, hi_a, ec_a}), 0);
    do_reset();

    // Lock again, then drop enable on a rise cycle.
    for (int i = 0; i < 13; i++) begin
      en_a  = 1'b1;
      mon_a = (i % 2) != 0;
      cycle();
    end
    chk("relock_a", int'(locked_a), 1);
    en_a  = 1'b0;
    mon_a = 1'b1;
    cycle();
    chk("drop_en_valid", int'(valid_a), 0);
    chk("drop_en_err", int'(err_a), 0);
    chk("drop_en_err_count", int'(ec_a), 0);
    chk("drop_en_locked", int'(locked_a), 0);
    en_a = 1'b1;
    cycle();

    // Wrong ratio on div-4: period 6, 3 high.
    for (int i = 0; i < 48; i++) begin
      en_b  = 1'b1;
      mon_b = (i % 6) < 3;
      cycle();
    end
    chk("wrong_ratio_period", int'(per_b), 6);
    chk("wrong_ratio_high", int'(hi_b), 3);
    chk("wrong_ratio_locked", int'(locked_b), 0);
    chk("wrong_ratio_err_count", int'(ec_b), 6);

    // Duty error: period 4 with 3 high, then good periods must rebuild the run.
    for (int i = 0; i < 16; i++) begin
      mon_b = (i % 4) < 3;
      cycle();
    end
    chk("duty_high", int'(hi_b), 3);
    chk("duty_period", int'(per_b), 4);
    for (int j = 0; j < 20; j++) begin
      mon_b = (j % 4) < 2;
      cycle();
      if (j == 12) chk("duty_run_3_unlocked", int'(locked_b), 0);
      if (j == 16) chk("duty_run_4_locked", int'(locked_b), 1);
    end

    // Error counter saturation: period 2 against an expected 4.
    for (int s = 0; s < 620; s++) begin
      mon_b = (s % 2) == 0;
      cycle();
    end
    chk("err_count_saturated", int'(ec_b), 255);
    for (int s = 0; s < 20; s++) begin
      mon_b = (s % 2) == 0;
      cycle();
    end
    chk("err_count_held_255", int'(ec_b), 255);

    // Randomized segments on both instances against the model.
    do_reset();
    ra = 0; rb = 0; posa = 0; posb = 0; pa = 1; pb = 1; ha = 0; hb = 0;
    for (int c = 0; c < 3000; c++) begin
      if (ra == 0) begin new_seg(DIV_A, pa, ha, ra); posa = 0; end
      if (rb == 0) begin new_seg(DIV_B, pb, hb, rb); posb = 0; end
      mon_a = posa < ha;
      mon_b = posb < hb;
      posa = (posa + 1) % pa;
      posb = (posb + 1) % pb;
      ra--;
      rb--;
      en_a = $urandom_range(0, 63) != 0;
      en_b = $urandom_range(0, 63) != 0;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
